div_seq: RTL and testbench
==========================

# div_seq

Multi-cycle divide sequencer for DIV/DIVU in the EXE stage. Accepts a divide request from EXE, runs a 32-iteration radix-2 restoring division on magnitudes, applies the sign correction and returns quotient (LO) and remainder (HI). While the division is in progress it holds `stallreq_div` high so the pipeline controller freezes IF/ID/EXE. It also takes a flush from the exception logic, which cancels an in-flight division.

## Interface
Parameters:
- `DATA_W`, 32: operand and result width. Only 32 is supported.

Ports:
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `resetn`  in  1  reset, synchronous and active-low.
- `flush`  in  1  pipeline flush (exception/ERET); synchronous cancel.
- `div_start`  in  1  EXE holds a DIV/DIVU; held high while stalled.
- `div_signed`  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with `div_start`.
- `dividend`  in  32  rs operand; sampled at accept.
- `divisor`  in  32  rt operand; sampled at accept.
- `div_ready`  out  1  one-cycle pulse; `div_hi`/`div_lo` valid this cycle.
- `div_hi`  out  32  remainder.
- `div_lo`  out  32  quotient.
- `stallreq_div`  out  1  stall request to pipeline control.
- `div_busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, BUSY, FIX, DONE. Reset and flush force IDLE, clear the counter, and clear `div_hi`/`div_lo`/`div_ready` to 0.
- IDLE with `div_start`=1 and `flush`=0 (accept):
  - Latch the sign flags qneg = signed & (a[31]^b[31]) and rneg = signed & a[31].
  - Latch |a| and |b|; magnitudes are taken only when signed, otherwise raw values are used.
  - If `divisor`==0, go to DONE with q=32'hFFFFFFFF and r=dividend (raw).
  - Otherwise go to BUSY with the 6-bit iteration counter at 0, partial remainder 0 and the quotient register holding |a|.
- BUSY, one iteration per cycle:
  - t = {rem[31:0], q[31]} − {1'b0,|b|}, computed at 33 bits.
  - If t is non-negative, rem=t[31:0] and q={q[30:0],1}. Otherwise rem={rem[30:0],q[31]} and q={q[30:0],0}.
  - The counter increments each iteration. The iteration taken with counter==31 moves to FIX.
- FIX:
  - lo = qneg ? −q : q; hi = rneg ? −rem : rem, both modulo 2^32.
  - These are registered into `div_lo`/`div_hi`; next state is DONE.
- DONE: `div_ready`=1 for exactly this cycle; next state is IDLE unconditionally.
  - A `div_start` seen in DONE is not accepted; the pipeline advances on this cycle, so the following cycle carries the next instruction.
  - `div_hi`/`div_lo` hold their value until the next accept or a flush.
- `stallreq_div` = (`div_start` & state≠DONE) | state∈{BUSY,FIX}; combinational, with no extra cycle of latency.
- Overflow case: 0x80000000 / −1 (signed) gives lo=32'h80000000 and hi=0. No exception is raised; the result follows from the magnitude path and wrap-around.
- `flush` has priority over `div_start` and over every state transition.
- An active reset overrides everything, including an in-flight division; there is no partial output.

## Timing
- The request is seen in cycle 0 and accepted at edge 1. BUSY occupies cycles 1–32, FIX cycle 33, DONE cycle 34.
  - `div_ready` is high in cycle 34.
  - `stallreq_div` is high in cycles 0–33 and low in cycle 34.
- Divide by zero: accepted at edge 1; DONE and `div_ready` in cycle 1; `stallreq_div` high only in cycle 0.
- Back-to-back divides: DONE in cycle n means IDLE in cycle n+1. A new start in cycle n+1 is accepted at edge n+2, so there is one idle cycle minimum between requests.
- Flush in cycle k: IDLE from cycle k+1. If `div_start` is high in cycle k+1, it is accepted at edge k+2.
- Operands only need to be stable in the accept cycle; later changes are ignored.

## Test plan
- Unsigned 100 / 7, start held from cycle 0 -> `div_ready` only in cycle 34, lo=14, hi=2, stall high cycles 0–33.
- Signed −7 / 2 (0xFFFFFFF9 / 2) -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Signed 7 / −2 -> lo=0xFFFFFFFD, hi=1. Unsigned 0xFFFFFFF9 / 2 -> lo=0x7FFFFFFC, hi=1.
- Divide by zero, dividend 0x12345678 -> ready in cycle 1, lo=0xFFFFFFFF, hi=0x12345678.
- Signed 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, no hang, ready in cycle 34.
- Flush in cycle 10 of a division -> no `div_ready`, `div_busy`=0 from cycle 11. A new 9 / 3 started in cycle 11 gives ready in cycle 45, lo=3, hi=0.
- `resetn`=0 in cycle 20 mid-division -> all outputs 0 the next cycle. Two back-to-back divides (start, DONE, then start again the next cycle) give two independent correct results, 35 cycles apart.

Source files
------------

// File: rtl/div_seq.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in EXE.
// Holds stallreq_div while busy and returns quotient on div_lo, remainder on div_hi.
module div_seq #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              div_start,
    input  logic              div_signed,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              div_ready,
    output logic [DATA_W-1:0] div_hi,
    output logic [DATA_W-1:0] div_lo,
    output logic              stallreq_div,
    output logic              div_busy
);

    // Handshake: div_start is a level held by EXE until the pipeline advances;
    // the request is taken on the first IDLE edge without flush, and completion
    // is the single-cycle div_ready pulse in DONE (stall already low there).

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [5:0] CNT_LAST = 6'(DATA_W - 1);

    state_t            state;
    logic [5:0]        cnt;
    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] quo;
    logic [DATA_W-1:0] b_mag;
    logic              qneg;
    logic              rneg;

    logic [DATA_W-1:0] a_abs;
    logic [DATA_W-1:0] b_abs;
    logic [DATA_W:0]   trial;

    always_comb begin
        a_abs = (div_signed && dividend[DATA_W-1]) ? -dividend : dividend;
        b_abs = (div_signed && divisor[DATA_W-1])  ? -divisor  : divisor;
        trial = {rem, quo[DATA_W-1]} - {1'b0, b_mag};
    end

    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            state     <= IDLE;
            cnt       <= '0;
            rem       <= '0;
            quo       <= '0;
            b_mag     <= '0;
            qneg      <= 1'b0;
            rneg      <= 1'b0;
            div_hi    <= '0;
            div_lo    <= '0;
            div_ready <= 1'b0;
        end else begin
            div_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (div_start) begin
                        qneg  <= div_signed & (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
                        rneg  <= div_signed & dividend[DATA_W-1];
                        b_mag <= b_abs;
                        cnt   <= '0;
                        rem   <= '0;
                        quo   <= a_abs;
                        if (divisor == '0) begin
                            // Divide by zero skips the iterations and reports raw operands.
                            div_lo    <= '1;
                            div_hi    <= dividend;
                            div_ready <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (!trial[DATA_W]) begin
                        rem <= trial[DATA_W-1:0];
                        quo <= {quo[DATA_W-2:0], 1'b1};
                    end else begin
                        rem <= {rem[DATA_W-2:0], quo[DATA_W-1]};
                        quo <= {quo[DATA_W-2:0], 1'b0};
                    end
                    cnt <= cnt + 6'd1;
                    if (cnt == CNT_LAST) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    div_lo    <= qneg ? -quo : quo;
                    div_hi    <= rneg ? -rem : rem;
                    div_ready <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        stallreq_div = (div_start && (state != DONE)) || (state == BUSY) || (state == FIX);
        div_busy     = (state != IDLE);
    end

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: arithmetic model plus per-cycle stall/busy/ready timing checks.
module tb_div_seq;

    logic        clk;
    logic        resetn;
    logic        flush;
    logic        div_start;
    logic        div_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        div_ready;
    logic [31:0] div_hi;
    logic [31:0] div_lo;
    logic        stallreq_div;
    logic        div_busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [63:0] exp_q[$];
    int          exp_cyc_q[$];

    div_seq #(.DATA_W(32)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .flush        (flush),
        .div_start    (div_start),
        .div_signed   (div_signed),
        .dividend     (dividend),
        .divisor      (divisor),
        .div_ready    (div_ready),
        .div_hi       (div_hi),
        .div_lo       (div_lo),
        .stallreq_div (stallreq_div),
        .div_busy     (div_busy)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #400000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Result model: returns {hi, lo} from plain integer division semantics.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa, sb;
        logic [31:0] q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    // Scoreboard: every div_ready pulse must match the oldest expected result and cycle.
    always @(negedge clk) begin
        if (div_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ready act=1 exp=0 (cycle %0d)", cyc);
            end else begin
                logic [63:0] e;
                int          ec;
                e  = exp_q.pop_front();
                ec = exp_cyc_q.pop_front();
                chk("div_lo", div_lo, e[31:0]);
                chk("div_hi", div_hi, e[63:32]);
                chk("ready_cycle", 32'(cyc), 32'(ec));
            end
        end
    end

    // Called 1ns after a rising edge; that cycle is cycle 0 of the request.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s);
        int c0, lat;
        bit seen;
        lat = (b == 32'd0) ? 1 : 34;
        c0  = cyc;
        exp_q.push_back(model(a, b, s));
        exp_cyc_q.push_back(c0 + lat);
        div_start  = 1'b1;
        div_signed = s;
        dividend   = a;
        divisor    = b;
        seen       = 1'b0;
        for (int rel = 0; rel <= lat + 2 && !seen; rel++) begin
            if (rel > 0) begin
                @(posedge clk);
                #1;
                dividend   = $urandom;
                divisor    = $urandom;
                div_signed = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            chk("stallreq_div", 32'(stallreq_div), 32'(rel < lat));
            chk("div_busy", 32'(div_busy), 32'(rel >= 1));
            if (div_ready) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout act=none exp=cycle_%0d", c0 + lat);
        end
        @(posedge clk);
        #1;
        div_start = 1'b0;
    endtask

    // Starts a divide and flushes it in relative cycle k; returns in cycle k+1.
    task automatic run_flushed(input logic [31:0] a, input logic [31:0] b, input logic s, input int k);
        div_start  = 1'b1;
        div_signed = s;
        dividend   = a;
        divisor    = b;
        for (int rel = 0; rel <= k; rel++) begin
            if (rel > 0) begin
                @(posedge clk);
                #1;
            end
            if (rel == k) flush = 1'b1;
            @(negedge clk);
            chk("flush_stall", 32'(stallreq_div), 32'd1);
            chk("flush_no_ready", 32'(div_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_busy", 32'(div_busy), 32'd0);
        chk("flush_lo", div_lo, 32'd0);
        chk("flush_hi", div_hi, 32'd0);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] lo;
        logic [31:0] hi;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2};
        vecs[1] = '{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF};
        vecs[2] = '{32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1};
        vecs[3] = '{32'hFFFF_FFF9,  32'd2,          1'b0, 32'h7FFF_FFFC,  32'd1};
        vecs[4] = '{32'h1234_5678,  32'd0,          1'b0, 32'hFFFF_FFFF,  32'h1234_5678};
        vecs[5] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0};
        vecs[6] = '{32'hFFFF_FF9C,  32'hFFFF_FFF9,  1'b1, 32'd14,         32'hFFFF_FFFE};
        vecs[7] = '{32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0};
        vecs[8] = '{32'd5,          32'd10,         1'b0, 32'd0,          32'd5};
        vecs[9] = '{32'h8000_0000,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'h8000_0000};

        resetn     = 1'b0;
        flush      = 1'b0;
        div_start  = 1'b0;
        div_signed = 1'b0;
        dividend   = '0;
        divisor    = '0;

        // Pin the model against hand-computed results.
        for (int i = 0; i < 10; i++) begin
            logic [63:0] m;
            m = model(vecs[i].a, vecs[i].b, vecs[i].s);
            chk($sformatf("model_lo_%0d", i), m[31:0], vecs[i].lo);
            chk($sformatf("model_hi_%0d", i), m[63:32], vecs[i].hi);
        end

        idle_cycles(3);
        @(negedge clk);
        chk("rst_ready", 32'(div_ready), 32'd0);
        chk("rst_lo", div_lo, 32'd0);
        chk("rst_hi", div_hi, 32'd0);
        chk("rst_busy", 32'(div_busy), 32'd0);
        chk("rst_stall", 32'(stallreq_div), 32'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        idle_cycles(2);

        for (int i = 0; i < 10; i++) begin
            run_div(vecs[i].a, vecs[i].b, vecs[i].s);
            idle_cycles(2);
        end

        // Back-to-back: second start in the cycle right after DONE.
        run_div(32'd1000, 32'd33, 1'b0);
        run_div(32'hFFFF_FC18, 32'd33, 1'b1);
        idle_cycles(1);

        // Flush in cycle 10, new 9/3 in cycle 11 (ready 34 cycles later, cycle 45).
        run_flushed(32'd100, 32'd7, 1'b0, 10);
        run_div(32'd9, 32'd3, 1'b0);
        idle_cycles(1);

        // Reset in cycle 20 of a division clears everything the next cycle.
        div_start  = 1'b1;
        div_signed = 1'b0;
        dividend   = 32'd1000;
        divisor    = 32'd3;
        idle_cycles(20);
        resetn    = 1'b0;
        div_start = 1'b0;
        idle_cycles(1);
        @(negedge clk);
        chk("midrst_ready", 32'(div_ready), 32'd0);
        chk("midrst_lo", div_lo, 32'd0);
        chk("midrst_hi", div_hi, 32'd0);
        chk("midrst_busy", 32'(div_busy), 32'd0);
        chk("midrst_stall", 32'(stallreq_div), 32'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        idle_cycles(2);

        run_div(32'd77, 32'd7, 1'b1);
        idle_cycles(40);

        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
